// File: rtl/mips_dcache_pkg.sv
// Shared constants and types for the direct-mapped write-through data cache.
// Holds the FSM state encoding and the default geometry.
package mips_dcache_pkg;

    localparam int DEF_LINES      = 16;
    localparam int DEF_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mips_dcache_if.sv
// Core-side and external-memory-side signal bundle of the data cache.
// The slave modport is the cache's view; master is the core/memory environment.
interface mips_dcache_if;
    logic        core_ren;
    logic        core_wen;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_ack;
    logic [31:0] ext_rdata;

    modport slave (
        input  core_ren, core_wen, core_addr, core_wdata, ext_ack, ext_rdata,
        output core_rdata, core_stall, ext_req, ext_we, ext_addr, ext_wdata
    );

    modport master (
        output core_ren, core_wen, core_addr, core_wdata, ext_ack, ext_rdata,
        input  core_rdata, core_stall, ext_req, ext_we, ext_addr, ext_wdata
    );
endinterface

// File: rtl/mips_dcache_array.sv
// Tag, valid and data storage: asynchronous read, one word write port and one tag/valid port.
// Only the valid bits are reset, so a partially filled line can never be seen as a hit.
module dcache_array #(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [$clog2(LINES)-1:0]      i_rd_idx,
    input  logic [$clog2(LINE_WORDS)-1:0] i_rd_off,
    output logic                          o_rd_valid,
    output logic [TAG_W-1:0]              o_rd_tag,
    output logic [31:0]                   o_rd_word,
    input  logic                          i_wr_en,
    input  logic [$clog2(LINES)-1:0]      i_wr_idx,
    input  logic [$clog2(LINE_WORDS)-1:0] i_wr_off,
    input  logic [31:0]                   i_wr_data,
    input  logic                          i_tv_we,
    input  logic [$clog2(LINES)-1:0]      i_tv_idx,
    input  logic                          i_tv_valid,
    input  logic [TAG_W-1:0]              i_tv_tag
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES][LINE_WORDS];

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_word  = r_data[i_rd_idx][i_rd_off];

    // Valid bits: cleared asynchronously, set/cleared via the tag/valid port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else if (i_tv_we) begin
            r_valid[i_tv_idx] <= i_tv_valid;
        end
    end

    // Tag storage.
    always_ff @(posedge i_clk) begin
        if (i_tv_we) begin
            r_tag[i_tv_idx] <= i_tv_tag;
        end
    end

    // Data word storage.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_data[i_wr_idx][i_wr_off] <= i_wr_data;
        end
    end

endmodule

// File: rtl/mips_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MIPS MEM stage.
// Read hits return combinationally; refills and write-throughs stall the core.
module mips_dcache
    import mips_dcache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    mips_dcache_if.slave  bus
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int LINE_W = 30 - OFF_W;
    localparam int TAG_W  = LINE_W - IDX_W;

    logic [OFF_W-1:0]  w_off;
    logic [LINE_W-1:0] w_line;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_unused_addr;
    logic              w_rd_valid;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [31:0]       w_rd_word;
    logic              w_hit;
    logic              w_ack;
    logic              w_last;

    state_t            r_state, w_state_nxt;
    logic [OFF_W-1:0]  r_cnt, w_cnt_nxt;
    logic [LINE_W-1:0] r_line, w_line_nxt;
    logic              r_ext_req, w_req_nxt;
    logic              r_ext_we, w_we_nxt;
    logic [31:0]       r_ext_addr, w_addr_nxt;
    logic [31:0]       r_ext_wdata, w_wdata_nxt;

    logic              w_stall;
    logic [31:0]       w_rdata;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [OFF_W-1:0]  w_wr_off;
    logic [31:0]       w_wr_data;
    logic              w_tv_we;
    logic [IDX_W-1:0]  w_tv_idx;
    logic              w_tv_valid;
    logic [TAG_W-1:0]  w_tv_tag;

    assign w_off         = bus.core_addr[OFF_W+1:2];
    assign w_line        = bus.core_addr[31:OFF_W+2];
    assign w_idx         = w_line[IDX_W-1:0];
    assign w_tag         = w_line[LINE_W-1:IDX_W];
    assign w_unused_addr = ^bus.core_addr[1:0];
    assign w_hit         = w_rd_valid && (w_rd_tag == w_tag);
    // An ack is only meaningful while a beat is actually outstanding.
    assign w_ack         = r_ext_req && bus.ext_ack;
    assign w_last        = (r_cnt == OFF_W'(LINE_WORDS - 1));

    dcache_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_array (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rd_idx   (w_idx),
        .i_rd_off   (w_off),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_word  (w_rd_word),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_wr_idx),
        .i_wr_off   (w_wr_off),
        .i_wr_data  (w_wr_data),
        .i_tv_we    (w_tv_we),
        .i_tv_idx   (w_tv_idx),
        .i_tv_valid (w_tv_valid),
        .i_tv_tag   (w_tv_tag)
    );

    // Next-state, next-register and array-control logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_line_nxt  = r_line;
        w_req_nxt   = r_ext_req;
        w_we_nxt    = r_ext_we;
        w_addr_nxt  = r_ext_addr;
        w_wdata_nxt = r_ext_wdata;
        w_stall     = 1'b0;
        w_rdata     = 32'd0;
        w_wr_en     = 1'b0;
        w_wr_idx    = w_idx;
        w_wr_off    = w_off;
        w_wr_data   = bus.core_wdata;
        w_tv_we     = 1'b0;
        w_tv_idx    = w_idx;
        w_tv_valid  = 1'b0;
        w_tv_tag    = w_tag;
        case (r_state)
            ST_IDLE: begin
                if (bus.core_wen) begin
                    w_stall     = 1'b1;
                    w_wr_en     = w_hit;
                    w_state_nxt = ST_WRITE;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = {bus.core_addr[31:2], 2'b00};
                    w_wdata_nxt = bus.core_wdata;
                end else if (bus.core_ren) begin
                    if (w_hit) begin
                        w_rdata = w_rd_word;
                    end else begin
                        w_stall     = 1'b1;
                        w_tv_we     = 1'b1;
                        w_line_nxt  = w_line;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_REFILL;
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = 1'b0;
                        w_addr_nxt  = {w_line, {(OFF_W + 2){1'b0}}};
                    end
                end else begin
                    w_stall = 1'b0;
                end
            end
            ST_REFILL: begin
                w_stall  = 1'b1;
                w_wr_idx = r_line[IDX_W-1:0];
                w_wr_off = r_cnt;
                w_wr_data = bus.ext_rdata;
                if (w_ack) begin
                    w_wr_en   = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_last) begin
                        w_tv_we     = 1'b1;
                        w_tv_idx    = r_line[IDX_W-1:0];
                        w_tv_valid  = 1'b1;
                        w_tv_tag    = r_line[LINE_W-1:IDX_W];
                        w_state_nxt = ST_IDLE;
                        w_req_nxt   = 1'b0;
                    end else begin
                        w_addr_nxt = r_ext_addr + 32'd4;
                    end
                end else begin
                    w_wr_en = 1'b0;
                end
            end
            ST_WRITE: begin
                w_stall = 1'b1;
                if (w_ack) begin
                    w_state_nxt = ST_DONE;
                    w_req_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                end else begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Beat counter, latched line and registered external bus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_line      <= '0;
            r_ext_req   <= 1'b0;
            r_ext_we    <= 1'b0;
            r_ext_addr  <= 32'd0;
            r_ext_wdata <= 32'd0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_line      <= w_line_nxt;
            r_ext_req   <= w_req_nxt;
            r_ext_we    <= w_we_nxt;
            r_ext_addr  <= w_addr_nxt;
            r_ext_wdata <= w_wdata_nxt;
        end
    end

    assign bus.core_stall = w_stall;
    assign bus.core_rdata = w_rdata;
    assign bus.ext_req    = r_ext_req;
    assign bus.ext_we     = r_ext_we;
    assign bus.ext_addr   = r_ext_addr;
    assign bus.ext_wdata  = r_ext_wdata;

endmodule
